s13207_rd_sequencer: RTL and testbench



---
 rtl/s13207_pkg.sv | 20 ++
 rtl/s13207_settle_timer.sv | 31 +++
 rtl/s13207_rd_sequencer.sv | 148 ++++++++++++++
 tb/tb_s13207_rd_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/s13207_pkg.sv
// Shared types and field widths for the s13207 read-scan sequencer.
package s13207_pkg;

  localparam int SEL_W  = 4;
  localparam int BANK_W = 4;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = 4;

  // Chip-select pattern that keeps the cone deselected.
  localparam logic [3:0] CS_IDLE_MASK = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/s13207_settle_timer.sv
// Loadable down-counter with a zero flag. Measures the settle time between
// driving an address into the cone and sampling its output.
module s13207_settle_timer
  import s13207_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load takes priority over decrement; the counter stops at zero.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/s13207_rd_sequencer.sv
// Read-scan driver for the s13207 single-bit read-mux cone. Steps the cone
// select through a burst of register indices, samples the cone output after
// a settle delay and returns the samples as one packed response word.
//
//   state  | meaning
//   IDLE   | ready for a burst request, cone parked
//   SETUP  | new index presented to the cone, settle timer loaded
//   SETTLE | waiting for the cone output to settle
//   SAMPLE | capturing rd_bit into the response word
//   DONE   | response valid, cone parked, waiting for rsp_ready
module s13207_rd_sequencer
  import s13207_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int DATA_W     = 16
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BANK_W-1:0] req_bank,
  input  logic [SEL_W-1:0]  req_idx,
  input  logic [LEN_W-1:0]  req_len,
  output logic [SEL_W-1:0]  sel,
  output logic [BANK_W-1:0] bank,
  output logic              cs_en,
  output logic [3:0]        cs_mask,
  output logic              rd_gate,
  input  logic              rd_bit,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [LEN_W-1:0]  rsp_len
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    idx_q;
  logic [BANK_W-1:0]   bank_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    beat_q;
  logic [DATA_W-1:0]   data_q;
  logic                tmr_load;
  logic                tmr_dec;
  logic                tmr_zero;
  logic                last_beat;

  assign last_beat = (beat_q == len_q);

  s13207_settle_timer #(.W(CNT_W)) u_settle_timer (
    .ck       (ck),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // State register.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = SETUP;
      SETUP:   state_d = SETTLE;
      SETTLE:  if (tmr_zero) state_d = SAMPLE;
      SAMPLE:  state_d = last_beat ? DONE : SETUP;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Cone control and handshake outputs decoded from the state. These only
  // move on SETUP entry (from IDLE) or DONE entry, so the cone inputs stay
  // steady for the whole burst while rd_gate is high.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    cs_en     = 1'b0;
    cs_mask   = CS_IDLE_MASK;
    rd_gate   = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    unique case (state_q)
      IDLE:   req_ready = 1'b1;
      SETUP: begin
        cs_en    = 1'b1;
        cs_mask  = 4'h0;
        rd_gate  = 1'b1;
        tmr_load = 1'b1;
      end
      SETTLE: begin
        cs_en   = 1'b1;
        cs_mask = 4'h0;
        rd_gate = 1'b1;
        tmr_dec = 1'b1;
      end
      SAMPLE: begin
        cs_en   = 1'b1;
        cs_mask = 4'h0;
        rd_gate = 1'b1;
      end
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Burst capture, index/beat stepping and sample packing. The index wraps
  // within 4 bits and never carries into the bank.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      bank_q <= '0;
      len_q  <= '0;
      beat_q <= '0;
      data_q <= '0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        idx_q  <= req_idx;
        bank_q <= req_bank;
        len_q  <= req_len;
        beat_q <= '0;
        data_q <= '0;
      end else if (state_q == SAMPLE) begin
        data_q[beat_q] <= rd_bit;
        if (!last_beat) begin
          beat_q <= beat_q + 1'b1;
          idx_q  <= idx_q + 1'b1;
        end
      end
    end
  end

  assign sel      = idx_q;
  assign bank     = bank_q;
  assign rsp_data = data_q;
  assign rsp_len  = len_q;

endmodule

// File: tb/tb_s13207_rd_sequencer.sv
// Directed bench for the s13207 read-scan sequencer (SETTLE_CYC = 2).
module tb_s13207_rd_sequencer;

  logic        ck = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_bank;
  logic [3:0]  req_idx;
  logic [3:0]  req_len;
  logic [3:0]  sel;
  logic [3:0]  bank;
  logic        cs_en;
  logic [3:0]  cs_mask;
  logic        rd_gate;
  logic        rd_bit;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_len;

  // 0: constant rd_const, 1: parity of sel, 2: 1 while gated else X
  int          rd_mode;
  logic        rd_const;

  int checks   = 0;
  int failures = 0;

  assign rd_bit = (rd_mode == 0) ? rd_const :
                  (rd_mode == 1) ? ^sel :
                  (rd_gate ? 1'b1 : 1'bx);

  always #5 ck = ~ck;

  s13207_rd_sequencer dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_bank  (req_bank),
    .req_idx   (req_idx),
    .req_len   (req_len),
    .sel       (sel),
    .bank      (bank),
    .cs_en     (cs_en),
    .cs_mask   (cs_mask),
    .rd_gate   (rd_gate),
    .rd_bit    (rd_bit),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_len   (rsp_len)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 16'(req_ready), 16'h1);
    chk({tag, "_rsp_valid"}, 16'(rsp_valid), 16'h0);
    chk({tag, "_rsp_data"},  rsp_data,       16'h0);
    chk({tag, "_rsp_len"},   16'(rsp_len),   16'h0);
    chk({tag, "_sel"},       16'(sel),       16'h0);
    chk({tag, "_bank"},      16'(bank),      16'h0);
    chk({tag, "_cs_en"},     16'(cs_en),     16'h0);
    chk({tag, "_cs_mask"},   16'(cs_mask),   16'hF);
    chk({tag, "_rd_gate"},   16'(rd_gate),   16'h0);
  endtask

  // Present a request at a falling edge; returns at the falling edge after
  // the accepting rising edge, with req_valid dropped.
  task automatic send_req(input logic [3:0] b, input logic [3:0] i, input logic [3:0] l);
    req_bank  = b;
    req_idx   = i;
    req_len   = l;
    req_valid = 1'b1;
    @(negedge ck);
    req_valid = 1'b0;
  endtask

  // Counts falling edges (starting at 1 just after accept) until rsp_valid.
  task automatic wait_rsp(input int limit, output int n);
    n = 1;
    while (rsp_valid !== 1'b1 && n < limit) begin
      @(negedge ck);
      n++;
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge ck);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int         n;
    int         gate_cyc;
    int         nchg;
    int         bank_bad;
    int         vcount;
    logic [15:0] seqw;
    logic [3:0]  last;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_bank  = '0;
    req_idx   = '0;
    req_len   = '0;
    rsp_ready = 1'b0;
    rd_mode   = 0;
    rd_const  = 1'b0;

    // Reset values
    #12;
    chk_reset("rst");
    @(negedge ck);
    rst_n = 1'b1;
    @(negedge ck);
    chk("idle_ready", 16'(req_ready), 16'h1);

    // 1. Single beat, bank 1 idx 3, rd_bit = 1
    rd_const = 1'b1;
    send_req(4'h1, 4'h3, 4'h0);
    chk("t1_ready_drop", 16'(req_ready), 16'h0);
    chk("t1_sel",        16'(sel),       16'h3);
    chk("t1_bank",       16'(bank),      16'h1);
    chk("t1_cs_en",      16'(cs_en),     16'h1);
    chk("t1_cs_mask",    16'(cs_mask),   16'h0);
    gate_cyc = 0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 40) begin
      if (rd_gate === 1'b1 && sel === 4'h3) gate_cyc++;
      @(negedge ck);
      n++;
    end
    chk("t1_latency",   16'(n),        16'd5);
    chk("t1_beat_win",  16'(gate_cyc), 16'd4);
    chk("t1_data",      rsp_data,      16'h0001);
    chk("t1_len",       16'(rsp_len),  16'h0);
    chk("t1_done_cs",   16'(cs_en),    16'h0);
    chk("t1_done_mask", 16'(cs_mask),  16'hF);
    chk("t1_done_gate", 16'(rd_gate),  16'h0);
    release_rsp();
    chk("t1_valid_clr", 16'(rsp_valid), 16'h0);
    chk("t1_ready_back",16'(req_ready), 16'h1);

    // 2. Full burst, rd_bit = parity of index
    rd_mode = 1;
    send_req(4'h5, 4'h0, 4'hF);
    wait_rsp(200, n);
    chk("t2_setup_to_done", 16'(n - 1), 16'd64);
    chk("t2_data",          rsp_data,   16'h6996);
    chk("t2_len",           16'(rsp_len), 16'hF);
    release_rsp();

    // 3. Index wrap E,F,0,1 with constant bank
    send_req(4'h9, 4'hE, 4'h3);
    seqw     = 16'(sel);
    last     = sel;
    nchg     = 1;
    bank_bad = 0;
    n        = 1;
    while (rsp_valid !== 1'b1 && n < 60) begin
      if (bank !== 4'h9) bank_bad++;
      if (cs_en === 1'b1 && sel !== last) begin
        seqw = {seqw[11:0], sel};
        last = sel;
        nchg++;
      end
      @(negedge ck);
      n++;
    end
    chk("t3_sel_seq",  seqw,           16'hEF01);
    chk("t3_sel_cnt",  16'(nchg),      16'd4);
    chk("t3_bank_bad", 16'(bank_bad),  16'd0);
    chk("t3_data",     rsp_data,       16'h0009);
    chk("t3_len",      16'(rsp_len),   16'h3);
    release_rsp();

    // 4. Back-pressure in DONE, competing request ignored
    rd_mode  = 0;
    rd_const = 1'b1;
    send_req(4'hA, 4'h5, 4'h1);
    wait_rsp(40, n);
    chk("t4_latency", 16'(n), 16'd9);
    req_bank  = 4'h2;
    req_idx   = 4'h0;
    req_len   = 4'h0;
    req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge ck);
      chk("t4_hold_valid", 16'(rsp_valid), 16'h1);
      chk("t4_hold_data",  rsp_data,       16'h0003);
      chk("t4_hold_len",   16'(rsp_len),   16'h1);
      chk("t4_hold_ready", 16'(req_ready), 16'h0);
      chk("t4_hold_bank",  16'(bank),      16'hA);
    end
    rsp_ready = 1'b1;
    @(negedge ck);
    rsp_ready = 1'b0;
    chk("t4_idle_ready", 16'(req_ready), 16'h1);
    chk("t4_idle_valid", 16'(rsp_valid), 16'h0);
    @(negedge ck);
    req_valid = 1'b0;
    chk("t4_new_accept", 16'(req_ready), 16'h0);
    chk("t4_new_bank",   16'(bank),      16'h2);
    chk("t4_new_sel",    16'(sel),       16'h0);
    wait_rsp(40, n);
    chk("t4_new_data",   rsp_data,       16'h0001);
    release_rsp();

    // 5. Reset during beat 5 of a 16-beat burst
    send_req(4'h7, 4'h0, 4'hF);
    for (int c = 0; c < 21; c++) @(negedge ck);
    chk("t5_beat5_sel", 16'(sel), 16'h5);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("t5_async");
    @(negedge ck);
    rst_n = 1'b1;
    vcount = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge ck);
      if (rsp_valid !== 1'b0) vcount++;
    end
    chk("t5_no_rsp",   16'(vcount),    16'd0);
    chk("t5_ready",    16'(req_ready), 16'h1);
    chk("t5_data_clr", rsp_data,       16'h0);

    // 6. Park: rd_bit is X whenever the cone is not gated
    rd_mode = 2;
    chk("t6_idle_gate", 16'(rd_gate), 16'h0);
    chk("t6_idle_cs",   16'(cs_en),   16'h0);
    send_req(4'h3, 4'h9, 4'h0);
    wait_rsp(40, n);
    for (int c = 0; c < 4; c++) @(negedge ck);
    chk("t6_done_gate", 16'(rd_gate), 16'h0);
    chk("t6_done_cs",   16'(cs_en),   16'h0);
    chk("t6_data",      rsp_data,     16'h0001);
    release_rsp();
    for (int c = 0; c < 3; c++) @(negedge ck);
    chk("t6_idle_data", rsp_data,     16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
